// File: rtl/axi_cmd_reg_map_pkg.sv
// axi_cmd_reg_map shared definitions:
// opcodes, FSM states, header fields.
package cmd_pkg;

  // 'W' matches the command generator's WRITE_CMD byte
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  localparam int OPC_LSB = 24;
  localparam int CNT_LSB = 0;

  typedef enum logic [2:0] {
    HDR,
    ADDR,
    DATA,
    DRAIN,
    RB
  } state_e;

  function automatic logic [7:0] hdr_op(
    input logic [31:0] w
  );
    return w[OPC_LSB +: 8];
  endfunction

  function automatic logic [7:0] hdr_cnt(
    input logic [31:0] w
  );
    return w[CNT_LSB +: 8];
  endfunction

endpackage

// File: rtl/axi_cmd_reg_map_if.sv
// Command-in / readback-out stream bundle.
// slave: register map view; master: driver view.
interface axi_cmd_reg_map_if;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid,
    input  s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata,
    output m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid,
    output s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata,
    input  m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/axi_cmd_reg_map_sat_counter.sv
// Saturating event counter, holds at all-ones.
// clk_i/rst_ni, inc_i event, cnt_o count.
module cmd_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else if (inc_i && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/axi_cmd_reg_map.sv
// Command-frame decoder writing a register bank, with readback.
// Ports: axi_tclk/axi_tresetn, bus (streams), reg_bus, reg_update, cmd_done/err, counters.
module axi_cmd_reg_map
  import cmd_pkg::*;
#(
  parameter int REG_WIDTH = 4,
  parameter int NUM_REG   = 6,
  parameter int CNT_WIDTH = 16
) (
  input  logic axi_tclk,
  input  logic axi_tresetn,
  axi_cmd_reg_map_if.slave bus,
  output logic [8*REG_WIDTH*NUM_REG-1:0] reg_bus,
  output logic [NUM_REG-1:0] reg_update,
  output logic cmd_done,
  output logic cmd_err,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] err_count
);
  localparam int RW = 8*REG_WIDTH;
  localparam logic [7:0] LAST_IDX = 8'(NUM_REG-1);

  state_e state_q, state_d;
  logic [7:0] n_q, n_d, addr_q, addr_d;
  logic [7:0] idx_q, idx_d, rd_idx;
  logic bad_q, bad_d, rdy_q;
  logic done_q, done_d, err_q, err_d;
  logic mv_q, mv_d, ml_q, ml_d;
  logic [31:0] md_q, md_d, rd_val, wd;
  logic [RW-1:0] regs_q [NUM_REG];
  logic [RW-1:0] regs_d [NUM_REG];
  logic [NUM_REG-1:0] upd_q, upd_d;
  logic acc, last, oor;

  assign acc  = bus.s_axis_tvalid & rdy_q;
  assign wd   = bus.s_axis_tdata;
  assign last = bus.s_axis_tlast;
  assign oor  = 32'(addr_q) >= NUM_REG;

  // next word to present: 0 on entry, else idx+1
  assign rd_idx = mv_q ? idx_q + 8'd1 : 8'd0;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REG; i++)
      if (rd_idx == 8'(i))
        rd_val = 32'(regs_q[i]);
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    bad_d   = bad_q;
    idx_d   = idx_q;
    mv_d    = mv_q;
    ml_d    = ml_q;
    md_d    = md_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    upd_d   = '0;
    regs_d  = regs_q;
    unique case (state_q)
      HDR: if (acc) begin
        if (hdr_op(wd) == OP_WRITE) begin
          if (hdr_cnt(wd) == 8'd0) begin
            if (last) done_d = 1'b1;
            else state_d = DRAIN;
          end else if (last) begin
            err_d = 1'b1;
          end else begin
            state_d = ADDR;
            n_d     = hdr_cnt(wd);
            bad_d   = 1'b0;
          end
        end else if (hdr_op(wd) == OP_READ) begin
          state_d = last ? RB : DRAIN;
        end else if (last) begin
          err_d = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      ADDR: if (acc) begin
        addr_d = wd[7:0];
        if (last) begin
          err_d   = 1'b1;
          state_d = HDR;
        end else begin
          state_d = DATA;
        end
      end
      DATA: if (acc) begin
        if (!oor)
          for (int i = 0; i < NUM_REG; i++)
            if (addr_q == 8'(i)) begin
              regs_d[i] = wd[RW-1:0];
              upd_d[i]  = 1'b1;
            end
        n_d   = n_q - 8'd1;
        bad_d = bad_q | oor;
        if (n_q == 8'd1) begin
          if (last) begin
            state_d = HDR;
            if (bad_q || oor) err_d = 1'b1;
            else done_d = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else if (last) begin
          err_d   = 1'b1;
          state_d = HDR;
        end else begin
          state_d = ADDR;
        end
      end
      DRAIN: if (acc && last) begin
        err_d   = 1'b1;
        state_d = HDR;
      end
      RB: begin
        if (!mv_q) begin
          mv_d  = 1'b1;
          md_d  = rd_val;
          idx_d = 8'd0;
          ml_d  = (LAST_IDX == 8'd0);
        end else if (bus.m_axis_tready) begin
          if (ml_q) begin
            mv_d    = 1'b0;
            ml_d    = 1'b0;
            md_d    = '0;
            done_d  = 1'b1;
            state_d = HDR;
          end else begin
            idx_d = rd_idx;
            md_d  = rd_val;
            ml_d  = (rd_idx == LAST_IDX);
          end
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn) begin
      state_q <= HDR;
      n_q     <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      bad_q   <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mv_q    <= 1'b0;
      ml_q    <= 1'b0;
      md_q    <= '0;
      upd_q   <= '0;
      for (int i = 0; i < NUM_REG; i++)
        regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      rdy_q   <= (state_d != RB);
      done_q  <= done_d;
      err_q   <= err_d;
      mv_q    <= mv_d;
      ml_q    <= ml_d;
      md_q    <= md_d;
      upd_q   <= upd_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    reg_bus = '0;
    for (int i = 0; i < NUM_REG; i++)
      reg_bus[i*RW +: RW] = regs_q[i];
  end

  assign bus.s_axis_tready = rdy_q;
  assign bus.m_axis_tdata  = md_q;
  assign bus.m_axis_tvalid = mv_q;
  assign bus.m_axis_tlast  = ml_q;
  assign reg_update = upd_q;
  assign cmd_done   = done_q;
  assign cmd_err    = err_q;

  cmd_sat_counter #(.W(CNT_WIDTH)) u_frame_cnt (
    .clk_i  (axi_tclk),
    .rst_ni (axi_tresetn),
    .inc_i  (done_d),
    .cnt_o  (frame_count)
  );

  cmd_sat_counter #(.W(CNT_WIDTH)) u_err_cnt (
    .clk_i  (axi_tclk),
    .rst_ni (axi_tresetn),
    .inc_i  (err_d),
    .cnt_o  (err_count)
  );
endmodule

// File: tb/tb_axi_cmd_reg_map.sv
// Randomized self-checking bench for axi_cmd_reg_map.
// Frame-level reference model; small counters expose saturation.
module tb_axi_cmd_reg_map;
  localparam int RW = 4;
  localparam int NR = 6;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic axi_tclk = 1'b0;
  logic axi_tresetn = 1'b0;
  logic [8*RW*NR-1:0] reg_bus;
  logic [NR-1:0] reg_update;
  logic cmd_done, cmd_err;
  logic [CW-1:0] frame_count, err_count;

  axi_cmd_reg_map_if bus();

  axi_cmd_reg_map #(
    .REG_WIDTH(RW), .NUM_REG(NR), .CNT_WIDTH(CW)
  ) dut (
    .axi_tclk    (axi_tclk),
    .axi_tresetn (axi_tresetn),
    .bus         (bus.slave),
    .reg_bus     (reg_bus),
    .reg_update  (reg_update),
    .cmd_done    (cmd_done),
    .cmd_err     (cmd_err),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  always #5 axi_tclk = ~axi_tclk;

  int checks = 0;
  int failures = 0;
  int done_n = 0, err_n = 0, both_n = 0;
  int upd_n[NR];
  int exp_upd[NR];
  logic [31:0] exp_regs[NR];
  int exp_fc = 0, exp_ec = 0;
  logic [31:0] q[$];

  always @(negedge axi_tclk) begin
    if (cmd_done) done_n++;
    if (cmd_err) err_n++;
    if (cmd_done && cmd_err) both_n++;
    for (int i = 0; i < NR; i++)
      if (reg_update[i]) upd_n[i]++;
  end

  function automatic logic [31:0] rbv(input int i);
    return reg_bus[i*32 +: 32];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    exp_fc = 0;
    exp_ec = 0;
  endtask

  // Outcome of one tlast-terminated frame, applying its writes.
  task automatic model_frame(input logic [31:0] w[$],
                             output bit good, output bit isrb);
    int k, n, j;
    bit bad, ok;
    logic [7:0] a;
    k = w.size();
    n = int'(w[0][7:0]);
    good = 0;
    isrb = 0;
    if (w[0][31:24] == 8'h57) begin
      if (k == 1) good = (n == 0);
      else if (n != 0) begin
        bad = 0; ok = 1; j = 1;
        for (int p = 0; p < n; p++) begin
          if (j + 1 > k - 1) begin ok = 0; break; end
          a = w[j][7:0];
          if (int'(a) < NR) begin
            exp_regs[a] = w[j+1];
            exp_upd[a]++;
          end else bad = 1;
          j += 2;
        end
        good = ok && !bad && (j == k);
      end
    end else if (w[0][31:24] == 8'h52) begin
      if (k == 1) begin good = 1; isrb = 1; end
    end
    if (good) exp_fc = (exp_fc < CMAX) ? exp_fc + 1 : CMAX;
    else exp_ec = (exp_ec < CMAX) ? exp_ec + 1 : CMAX;
  endtask

  task automatic send_word(input logic [31:0] d, input bit l);
    int t = 0;
    repeat ($urandom_range(0, 1)) begin
      @(posedge axi_tclk); #1;
    end
    bus.s_axis_tdata = d;
    bus.s_axis_tlast = l;
    bus.s_axis_tvalid = 1'b1;
    forever begin
      @(negedge axi_tclk);
      if (bus.s_axis_tready) break;
      t++;
      if (t > 50) begin
        checks++; failures++;
        $display("FAIL send_timeout: tready=%b want 1", bus.s_axis_tready);
        break;
      end
    end
    @(posedge axi_tclk); #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w[$]);
    for (int i = 0; i < w.size(); i++)
      send_word(w[i], i == w.size() - 1);
  endtask

  task automatic do_readback(input logic [31:0] hdr);
    int got = 0, cyc = 0;
    bit pst = 0;
    logic [31:0] pd = '0;
    send_word(hdr, 1'b1);
    @(negedge axi_tclk);
    checks++;
    if (bus.m_axis_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL rb_latency_early: valid=%b want 0", bus.m_axis_tvalid);
    end
    @(posedge axi_tclk); #1;
    @(negedge axi_tclk);
    checks++;
    if (bus.m_axis_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL rb_latency: valid=%b want 1", bus.m_axis_tvalid);
    end
    while (got < NR && cyc < 300) begin
      checks++;
      if (bus.s_axis_tready !== 1'b0) begin
        failures++;
        $display("FAIL rb_tready: got %b want 0", bus.s_axis_tready);
      end
      if (pst) begin
        checks++;
        if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== pd) begin
          failures++;
          $display("FAIL rb_stall: got %b/%h want 1/%h",
                   bus.m_axis_tvalid, bus.m_axis_tdata, pd);
        end
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        checks++;
        if (bus.m_axis_tdata !== exp_regs[got] ||
            bus.m_axis_tlast !== (got == NR - 1)) begin
          failures++;
          $display("FAIL rb_word%0d: got %h/%b want %h/%b", got,
                   bus.m_axis_tdata, bus.m_axis_tlast,
                   exp_regs[got], got == NR - 1);
        end
        got++;
        pst = 0;
      end else begin
        pst = bus.m_axis_tvalid;
        pd = bus.m_axis_tdata;
      end
      @(posedge axi_tclk); #1;
      bus.m_axis_tready = 1'($urandom_range(0, 1));
      cyc++;
      @(negedge axi_tclk);
    end
    bus.m_axis_tready = 1'b0;
    checks++;
    if (got != NR) begin
      failures++;
      $display("FAIL rb_count: got %0d words want %0d", got, NR);
    end
    @(posedge axi_tclk); #1;
  endtask

  task automatic run_frame(input logic [31:0] w[$], input string tag);
    bit good, isrb;
    int d0, e0;
    d0 = done_n;
    e0 = err_n;
    model_frame(w, good, isrb);
    if (isrb) do_readback(w[0]);
    else send_frame(w);
    repeat (3) @(posedge axi_tclk);
    #1;
    checks++;
    if (done_n - d0 != int'(good) || err_n - e0 != int'(!good)) begin
      failures++;
      $display("FAIL %s_pulse: done=%0d err=%0d want %0d/%0d", tag,
               done_n - d0, err_n - e0, good, !good);
    end
    checks++;
    if (int'(frame_count) != exp_fc || int'(err_count) != exp_ec) begin
      failures++;
      $display("FAIL %s_cnt: got %0d/%0d want %0d/%0d", tag,
               frame_count, err_count, exp_fc, exp_ec);
    end
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (rbv(i) !== exp_regs[i] || upd_n[i] != exp_upd[i]) begin
        failures++;
        $display("FAIL %s_reg%0d: got %h upd %0d want %h upd %0d", tag,
                 i, rbv(i), upd_n[i], exp_regs[i], exp_upd[i]);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (reg_bus !== '0 || reg_update !== '0 || cmd_done !== 1'b0 ||
        cmd_err !== 1'b0 || frame_count !== '0 || err_count !== '0 ||
        bus.s_axis_tready !== 1'b0 || bus.m_axis_tvalid !== 1'b0 ||
        bus.m_axis_tlast !== 1'b0 || bus.m_axis_tdata !== '0) begin
      failures++;
      $display("FAIL %s: bus=%h fc=%0d ec=%0d rdy=%b mv=%b want all 0",
               tag, reg_bus, frame_count, err_count,
               bus.s_axis_tready, bus.m_axis_tvalid);
    end
  endtask

  task automatic release_reset();
    @(posedge axi_tclk); #1;
    axi_tresetn = 1'b1;
    @(negedge axi_tclk);
    checks++;
    if (bus.s_axis_tready !== 1'b0) begin
      failures++;
      $display("FAIL rdy_before_clk: got %b want 0", bus.s_axis_tready);
    end
    @(posedge axi_tclk); #1;
    checks++;
    if (bus.s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL rdy_after_clk: got %b want 1", bus.s_axis_tready);
    end
  endtask

  task automatic test_reset();
    #1;
    check_zero("reset_initial");
    repeat (3) @(posedge axi_tclk);
    #1;
    check_zero("reset_held");
    model_reset();
    release_reset();
  endtask

  task automatic test_write();
    q.delete();
    q.push_back(32'h57000002); q.push_back(32'h00000001);
    q.push_back(32'hDEADBEEF); q.push_back(32'h00000004);
    q.push_back(32'h12345678);
    run_frame(q, "write");
    checks++;
    if (rbv(1) !== 32'hDEADBEEF || rbv(4) !== 32'h12345678 ||
        frame_count !== 4'd1) begin
      failures++;
      $display("FAIL write_direct: got %h %h fc=%0d want deadbeef 12345678 1",
               rbv(1), rbv(4), frame_count);
    end
  endtask

  task automatic test_oor();
    q.delete();
    q.push_back(32'h57000001); q.push_back(32'h00000009);
    q.push_back(32'hAAAA5555);
    run_frame(q, "oor");
    checks++;
    if (err_count !== 4'd1) begin
      failures++;
      $display("FAIL oor_errcnt: got %0d want 1", err_count);
    end
  endtask

  task automatic test_early_tlast();
    q.delete();
    q.push_back(32'h57000002); q.push_back(32'h00000000);
    q.push_back(32'h00000011); q.push_back(32'h00000001);
    run_frame(q, "early");
    checks++;
    if (rbv(0) !== 32'h00000011) begin
      failures++;
      $display("FAIL early_reg0: got %h want 00000011", rbv(0));
    end
    q.delete();
    q.push_back(32'h57000001); q.push_back(32'h00000002);
    q.push_back(32'h00000022);
    run_frame(q, "after_early");
  endtask

  task automatic test_overlong();
    q.delete();
    q.push_back(32'h57000001); q.push_back(32'h00000003);
    q.push_back(32'hCAFEF00D); q.push_back(32'h57000000);
    q.push_back(32'h52000000); q.push_back(32'h00000001);
    run_frame(q, "overlong");
  endtask

  task automatic test_readback();
    q.delete();
    q.push_back(32'h52000000);
    run_frame(q, "readback");
  endtask

  task automatic test_reset_mid();
    send_word(32'h57000002, 1'b0);
    send_word(32'h00000005, 1'b0);
    @(negedge axi_tclk); #2;
    axi_tresetn = 1'b0;
    #1;
    check_zero("reset_mid_data");
    model_reset();
    release_reset();
    q.delete();
    q.push_back(32'h57000001); q.push_back(32'h00000005);
    q.push_back(32'h0BADF00D);
    run_frame(q, "post_reset1");
    send_word(32'h52000000, 1'b1);
    repeat (3) @(posedge axi_tclk);
    @(negedge axi_tclk); #2;
    checks++;
    if (bus.m_axis_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL rb_pre_reset: valid=%b want 1", bus.m_axis_tvalid);
    end
    axi_tresetn = 1'b0;
    #1;
    check_zero("reset_mid_rb");
    model_reset();
    release_reset();
    q.delete();
    q.push_back(32'h57000001); q.push_back(32'h00000003);
    q.push_back(32'h76543210);
    run_frame(q, "post_reset2");
  endtask

  task automatic test_random();
    int kind, n, m;
    logic [7:0] op;
    for (int f = 0; f < 40; f++) begin
      q.delete();
      kind = $urandom_range(0, 8);
      n = (kind == 3) ? 3 : $urandom_range(1, 3);
      if (kind <= 4) begin
        q.push_back({8'h57, 16'($urandom), 8'(n)});
        for (int p = 0; p < n; p++) begin
          if (kind == 2 && p == n - 1)
            q.push_back({24'($urandom), 8'($urandom_range(NR, 255))});
          else
            q.push_back({24'($urandom), 8'($urandom_range(0, NR - 1))});
          q.push_back($urandom);
        end
        if (kind == 3) begin
          m = $urandom_range(1, 5);
          q = q[0:m];
        end
        if (kind == 4)
          repeat ($urandom_range(1, 3)) q.push_back($urandom);
      end else if (kind == 5) begin
        q.push_back({8'h52, 24'($urandom)});
      end else if (kind == 6) begin
        q.push_back({8'h52, 24'($urandom)});
        q.push_back($urandom);
      end else if (kind == 7) begin
        op = 8'($urandom);
        if (op == 8'h57 || op == 8'h52) op = 8'h00;
        q.push_back({op, 24'($urandom)});
        repeat ($urandom_range(0, 2)) q.push_back($urandom);
      end else begin
        q.push_back({8'h57, 16'($urandom), 8'h00});
        q.push_back($urandom);
      end
      run_frame(q, "rand");
    end
  endtask

  task automatic test_saturation();
    for (int f = 0; f < CMAX + 3; f++) begin
      q.delete();
      q.push_back(32'h57000000);
      run_frame(q, "sat_good");
      q.delete();
      q.push_back(32'h99000000);
      run_frame(q, "sat_bad");
    end
    checks++;
    if (int'(frame_count) != CMAX || int'(err_count) != CMAX) begin
      failures++;
      $display("FAIL saturation: got %0d/%0d want %0d/%0d",
               frame_count, err_count, CMAX, CMAX);
    end
  endtask

  initial begin
    bus.s_axis_tdata = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < NR; i++) exp_upd[i] = 0;
    test_reset();
    test_write();
    test_oor();
    test_early_tlast();
    test_overlong();
    test_readback();
    test_reset_mid();
    test_random();
    test_readback();
    test_saturation();
    checks++;
    if (both_n != 0) begin
      failures++;
      $display("FAIL done_err_overlap: got %0d want 0", both_n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_cmd_reg_map.md
Name: axi_cmd_reg_map

Overview:
- Sits directly downstream of the RX command generator and consumes its 32-bit AXI-Stream of accepted command frames.
- Decodes each frame as a header followed by address/data pairs and writes a bank of NUM_REG control registers.
- Drives per-register update strobes, done/error pulses and saturating statistics.
- Answers readback frames by streaming the register bank out on a master AXI-Stream port.

Parameters:
- REG_WIDTH, 4: register width in bytes (1..4); data taken from word bits [8*REG_WIDTH-1:0], upper bits ignored.
- NUM_REG, 6: number of registers (1..256); valid addresses 0..NUM_REG-1.
- CNT_WIDTH, 16: width of the frame and error statistics counters.

Ports:
- axi_tclk  in  1  sole clock.
- axi_tresetn  in  1  reset, asynchronous assert, active-low.
- s_axis_tdata  in  32  command stream data from the command generator.
- s_axis_tvalid  in  1  command stream valid.
- s_axis_tlast  in  1  last word of frame.
- s_axis_tready  out  1  ready to command generator.
- m_axis_tdata  out  32  readback data, zero-extended register value.
- m_axis_tvalid  out  1  readback valid.
- m_axis_tlast  out  1  last readback word.
- m_axis_tready  in  1  readback ready.
- reg_bus  out  8*REG_WIDTH*NUM_REG  flattened registers; reg i at [i*8*REG_WIDTH +: 8*REG_WIDTH].
- reg_update  out  NUM_REG  one-cycle strobe per register, high the cycle its new value appears on reg_bus.
- cmd_done  out  1  one-cycle pulse: frame completed without error.
- cmd_err  out  1  one-cycle pulse: frame aborted or contained an error.
- frame_count  out  CNT_WIDTH  good frames, saturating.
- err_count  out  CNT_WIDTH  error frames, saturating.

Behaviour:
- Reset (axi_tresetn low, async): state HDR; all outputs, registers and counters 0; s_axis_tready 0 until the first clock after deassertion.
- Reset mid-frame or mid-readback aborts immediately. Upstream's remaining words are parsed as a fresh header.
- Accept on s_axis_tvalid & s_axis_tready. s_axis_tready is a registered 1 in HDR, ADDR, DATA and DRAIN, and 0 in RB.
- Header word: [31:24] opcode, [7:0] pair count N; other bits ignored.
  - 0x57 (write).
  - 0x52 (readback).
- HDR:
  - Write, N=0, tlast -> cmd_done, stay HDR.
  - Write, N>0, !tlast -> ADDR, load N.
  - Write, N>0, tlast -> cmd_err, stay HDR.
  - Write, N=0, !tlast -> DRAIN.
  - Readback with tlast -> RB.
  - Readback without tlast -> DRAIN.
  - Unknown opcode -> DRAIN if !tlast, else cmd_err and stay HDR.
- ADDR: latch address[7:0].
  - tlast -> cmd_err, HDR.
  - Otherwise -> DATA.
- DATA: write data to latched address on the accept edge; reg_update[addr] pulses in that same registered cycle.
  - Address >= NUM_REG: write suppressed, frame marked bad, parsing continues.
  - Decrement N.
  - N reaches 0 with tlast -> HDR; cmd_done if frame clean, else cmd_err.
  - N reaches 0 without tlast -> DRAIN (frame bad).
  - N>0 with tlast -> cmd_err, HDR.
  - Writes already committed earlier in an errored frame are not rolled back.
- DRAIN: discard words until an accepted tlast, then cmd_err and HDR.
- RB: emit registers 0..NUM_REG-1 in order, m_axis_tlast on index NUM_REG-1.
  - First m_axis_tvalid appears the cycle after entering RB.
  - Outputs are registered and held stable while m_axis_tready is low.
  - Last handshake -> cmd_done, HDR.
  - A register written on the same cycle it is sampled yields its old value.
- cmd_done and cmd_err are mutually exclusive.
  - frame_count increments with cmd_done; err_count increments with cmd_err.
  - Both saturate at all-ones.
- Latency: header accept to readback word 0 valid = 2 cycles; data word accept to reg_bus update = 1 cycle.

Decomposition:
- Shared package (cmd_pkg): opcode constants (OP_WRITE 8'h57, OP_READ 8'h52), state encoding (HDR, ADDR, DATA, DRAIN, RB), header field bit positions.
- OP_WRITE must match the ASCII 'W' byte used by the command generator's WRITE_CMD.
- One natural sub-module: cmd_sat_counter (CNT_WIDTH saturating incrementer), instantiated twice.

Test Plan:
- Write frame: 0x57000002, 0x00000001, 0xDEADBEEF, 0x00000004, 0x12345678 (tlast) -> reg1=DEADBEEF, reg4=12345678; reg_update bits 1 and 4 pulse once each; cmd_done; frame_count=1.
- Out-of-range write: header N=1, addr 0x00000009, data 0xAAAA5555 (tlast), NUM_REG=6 -> no register changes; cmd_err; err_count=1.
- Early tlast: header N=2, addr 0, data 0x11, addr 1 (tlast) -> reg0=0x11; cmd_err; next frame parses correctly from HDR.
- Overlong frame: header N=1 plus pair plus 3 extra words, tlast on last -> write applied; DRAIN swallows extras; single cmd_err.
- Readback: 0x52000000 (tlast) with m_axis_tready toggled 50% -> 6 words equal reg_bus contents in order; tlast only on word 5; data stable while stalled; s_axis_tready 0 throughout; cmd_done.
- Async reset asserted mid-DATA and mid-readback -> all outputs 0 asynchronously; following write frame executes normally.
- Saturation: force counters to 0xFFFF -> no wrap.
